// File: rtl/bpuf_response_sampler.sv
// rtl/bpuf_response_sampler.sv - excites a bistable-ring PUF cell and majority-votes its output into a response word
// Each bit: EXCITE -> SETTLE -> SAMPLE (VOTES synchronised samples) -> STORE; DONE pulses after RESP_BITS bits.
module bpuf_response_sampler #(
    parameter int RESP_BITS     = 8,
    parameter int EXCITE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int VOTES         = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 q_in_i,
    output logic                 excite_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [RESP_BITS-1:0] response_o,
    output logic [RESP_BITS-1:0] unstable_o
);

    localparam int CW    = $clog2(VOTES + 1);
    localparam int MAXC0 = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int MAXC  = (MAXC0 > VOTES) ? MAXC0 : VOTES;
    localparam int TW    = $clog2(MAXC + 1);
    localparam int IW    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        EXCITE,
        SETTLE,
        SAMPLE,
        STORE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        ones_q, ones_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic [RESP_BITS-1:0] unstable_q, unstable_d;
    logic [1:0]           q_sync_q;
    logic                 excite_q, excite_d;
    logic                 vote_one;
    logic                 vote_split;

    assign vote_one   = (ones_q > CW'(VOTES / 2));
    assign vote_split = (ones_q != '0) && (ones_q != CW'(VOTES));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        idx_d      = idx_q;
        response_d = response_q;
        unstable_d = unstable_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    response_d = '0;
                    unstable_d = '0;
                    idx_d      = '0;
                    ones_d     = '0;
                    cnt_d      = '0;
                    state_d    = EXCITE;
                end
            end
            EXCITE: begin
                if (cnt_q == TW'(EXCITE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == TW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            SAMPLE: begin
                ones_d = ones_q + CW'(q_sync_q[1]);
                if (cnt_q == TW'(VOTES - 1)) begin
                    cnt_d   = '0;
                    state_d = STORE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            STORE: begin
                for (int i = 0; i < RESP_BITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        response_d[i] = vote_one;
                        unstable_d[i] = vote_split;
                    end
                end
                ones_d = '0;
                if (idx_q == IW'(RESP_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = EXCITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drive excite from a flop loaded with the next state so it rises on the start edge without glitching.
    assign excite_d = (state_d == EXCITE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ones_q     <= '0;
            idx_q      <= '0;
            response_q <= '0;
            unstable_q <= '0;
            q_sync_q   <= '0;
            excite_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            idx_q      <= idx_d;
            response_q <= response_d;
            unstable_q <= unstable_d;
            q_sync_q   <= {q_sync_q[0], q_in_i};
            excite_q   <= excite_d;
        end
    end

    assign excite_o   = excite_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign response_o = response_q;
    assign unstable_o = unstable_q;

endmodule

// File: tb/tb_bpuf_response_sampler.sv
// tb/tb_bpuf_response_sampler.sv - randomized self-checking bench for bpuf_response_sampler
// Expected words come from summing each bit's sample window of the driven q_in schedule.
module tb_bpuf_response_sampler;

    localparam int RB     = 8;
    localparam int EC     = 4;
    localparam int SC     = 16;
    localparam int VT     = 7;
    localparam int P      = EC + SC + VT + 1;
    localparam int DONE_C = RB * P + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          q_in;
    logic          excite;
    logic          busy;
    logic          done;
    logic [RB-1:0] response;
    logic [RB-1:0] unstable;

    logic          start2;
    logic          q2;
    logic          excite2;
    logic          busy2;
    logic          done2;
    logic [0:0]    response2;
    logic [0:0]    unstable2;

    int checks = 0;
    int errors = 0;
    bit qa [0:255];

    always #5 clk = ~clk;

    bpuf_response_sampler #(
        .RESP_BITS(RB), .EXCITE_CYCLES(EC), .SETTLE_CYCLES(SC), .VOTES(VT)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .q_in_i(q_in),
        .excite_o(excite), .busy_o(busy), .done_o(done),
        .response_o(response), .unstable_o(unstable)
    );

    bpuf_response_sampler #(
        .RESP_BITS(1), .EXCITE_CYCLES(1), .SETTLE_CYCLES(2), .VOTES(1)
    ) u_dut_min (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .q_in_i(q2),
        .excite_o(excite2), .busy_o(busy2), .done_o(done2),
        .response_o(response2), .unstable_o(unstable2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit n is voted from q_in as driven in cycles n*P+EC+SC-1 .. +VT-1 (two-flop synchroniser delay).
    task automatic model(output logic [RB-1:0] r, output logic [RB-1:0] u);
        int ones;
        for (int n = 0; n < RB; n++) begin
            ones = 0;
            for (int k = 0; k < VT; k++) ones += int'(qa[n * P + EC + SC - 1 + k]);
            r[n] = (ones > VT / 2);
            u[n] = (ones != 0) && (ones != VT);
        end
    endtask

    task automatic fill_bits(input logic [RB-1:0] b);
        int n;
        for (int c = 0; c < 256; c++) begin
            n = (c == 0) ? 0 : (c - 1) / P;
            qa[c] = (n < RB) ? b[n] : 1'b0;
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < 256; c++) qa[c] = 1'($urandom_range(0, 1));
    endtask

    task automatic set_bit2_ones(input int k);
        for (int i = 0; i < VT; i++) qa[2 * P + EC + SC - 1 + i] = (i < k);
    endtask

    // Called while in cycle 0 (just after an edge); returns in cycle DONE_C+1.
    task automatic run(input bit glitch);
        logic [RB-1:0] er;
        logic [RB-1:0] eu;
        int dones;
        model(er, eu);
        dones = 0;
        start = 1'b1;
        q_in  = qa[0];
        for (int c = 1; c <= DONE_C + 1; c++) begin
            @(posedge clk);
            #1;
            start = glitch && (c == 2 || c == EC + SC + 3 || c == DONE_C);
            q_in  = qa[c];
            check_eq("excite", 32'(excite), 32'(c <= RB * P && ((c - 1) % P) < EC));
            check_eq("busy", 32'(busy), 32'(c <= DONE_C));
            check_eq("done", 32'(done), 32'(c == DONE_C));
            if (done) dones++;
            if (c == 1) begin
                check_eq("resp_clear", 32'(response), 32'h0);
                check_eq("unst_clear", 32'(unstable), 32'h0);
            end
            if (c >= DONE_C) begin
                check_eq("response", 32'(response), 32'(er));
                check_eq("unstable", 32'(unstable), 32'(eu));
            end
        end
        check_eq("done_count", 32'(dones), 32'd1);
        start = 1'b0;
    endtask

    task automatic reset_abort();
        int dones;
        dones = 0;
        start = 1'b1;
        q_in  = qa[0];
        for (int c = 1; c <= 3 * P + 2; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            q_in  = qa[c];
            if (c == 3 * P + 2) begin
                check_eq("abort_pre_excite", 32'(excite), 32'd1);
                rst = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_excite", 32'(excite), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_resp", 32'(response), 32'h0);
        check_eq("abort_unst", 32'(unstable), 32'h0);
        for (int c = 0; c < 2 * P; c++) begin
            if (done || busy) dones++;
            @(posedge clk);
            #1;
        end
        check_eq("abort_no_done", 32'(dones), 32'd0);
    endtask

    initial begin
        logic [RB-1:0] b;
        rst    = 1'b1;
        start  = 1'b0;
        q_in   = 1'b0;
        start2 = 1'b0;
        q2     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_excite", 32'(excite), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_resp", 32'(response), 32'h0);
        check_eq("rst_unst", 32'(unstable), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_busy", 32'(busy), 32'd0);

        start2 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            start2 = 1'b0;
            check_eq("min_done", 32'(done2), 32'(c == 6));
            check_eq("min_excite", 32'(excite2), 32'(c == 1));
            if (c == 6) begin
                check_eq("min_resp", 32'(response2), 32'd1);
                check_eq("min_unst", 32'(unstable2), 32'd0);
            end
        end

        fill_bits(8'hFF);
        run(1'b0);
        check_eq("ones_resp", 32'(response), 32'hFF);
        check_eq("ones_unst", 32'(unstable), 32'h00);

        b = 8'h4D;
        fill_bits(b);
        run(1'b0);
        check_eq("pat_resp", 32'(response), 32'h4D);
        check_eq("pat_unst", 32'(unstable), 32'h00);

        fill_bits(8'($urandom));
        set_bit2_ones(4);
        run(1'b0);
        check_eq("b2_4_resp", 32'(response[2]), 32'd1);
        check_eq("b2_4_unst", 32'(unstable[2]), 32'd1);

        fill_bits(8'($urandom));
        set_bit2_ones(3);
        run(1'b0);
        check_eq("b2_3_resp", 32'(response[2]), 32'd0);
        check_eq("b2_3_unst", 32'(unstable[2]), 32'd1);

        fill_random();
        run(1'b1);
        fill_random();
        run(1'b0);

        for (int i = 0; i < 4; i++) begin
            if (i[0]) fill_random();
            else fill_bits(8'($urandom));
            run(1'b0);
        end

        fill_bits(8'hFF);
        reset_abort();
        fill_random();
        run(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpuf_response_sampler.md
# bpuf_response_sampler

Downstream companion to the bistable-ring PUF cell. It owns the cell's `excite` input and consumes its `Q` output to produce a multi-bit response word. For each response bit it pulses `excite`, waits for the ring to settle, and samples the synchronised `Q` several times. It then majority-votes the samples, flags any non-unanimous bit as unstable, and after `RESP_BITS` evaluations presents the word with a one-cycle `done` pulse.

## Interface
- `RESP_BITS`, 8: response bits per run, ≥1.
- `EXCITE_CYCLES`, 4: cycles `excite` is held high per evaluation, ≥1.
- `SETTLE_CYCLES`, 16: cycles waited after excite release before sampling, ≥2 (covers the synchroniser).
- `VOTES`, 7: samples per bit; must be odd and ≥1.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; accepted only in IDLE.
- `q_in`  in  1  PUF cell output `Q`; asynchronous to `clk`; passed through a 2-flop synchroniser before any use.
- `excite`  out  1  registered drive to the PUF cell `excite` input.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `response` and `unstable` are valid.
- `response`  out  `RESP_BITS`  majority-voted bits, LSB evaluated first.
- `unstable`  out  `RESP_BITS`  bit i high if the votes for bit i were not unanimous.

## Operation
- Reset values: state IDLE, `excite`=0, `busy`=0, `done`=0, `response`=0, `unstable`=0, bit index=0, counters=0, synchroniser flops=0.
- FSM states: IDLE, EXCITE, SETTLE, SAMPLE, STORE, DONE.
- IDLE, `start`=1: clear `response`, `unstable`, bit index and the ones-counter, then go to EXCITE. `start`=0: stay.
- EXCITE: `excite`=1 for exactly `EXCITE_CYCLES` cycles, then go to SETTLE.
- SETTLE: `excite`=0 for `SETTLE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE: lasts `VOTES` cycles. Each cycle, the ones-counter adds the synchronised `q_in`. The counter is `$clog2(VOTES+1)` bits wide and cannot overflow.
- STORE: one cycle.
  - `response[idx]` = (ones > VOTES/2).
  - `unstable[idx]` = (ones ≠ 0 and ones ≠ VOTES).
  - The ones-counter is cleared.
  - If idx = `RESP_BITS`-1, go to DONE; otherwise idx+1 and go to EXCITE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `response`/`unstable` hold their values after DONE until the next accepted `start`.
- `start` is ignored in all states other than IDLE, including DONE. No queuing.
- `rst` asserted mid-run: return to reset values at the next edge. `excite` drops within one cycle. No `done` is produced for the aborted run.
- `excite` is never high outside EXCITE. It is glitch-free because it is driven directly from a flop.

## Timing
- `start` sampled high in IDLE at edge 0 → `excite` high in cycles 1..`EXCITE_CYCLES`.
- Per-bit period P = `EXCITE_CYCLES` + `SETTLE_CYCLES` + `VOTES` + 1. With defaults, P = 28.
- `done` is high in cycle `RESP_BITS`·P + 1 after the start edge. With defaults, cycle 225.
- Bit n's `excite` rising edge is in cycle n·P + 1.
- Bit n's samples are taken in cycles n·P + `EXCITE_CYCLES` + `SETTLE_CYCLES` + 1 .. +`VOTES` (synchronised value, i.e. `q_in` two cycles earlier).
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `start` is accepted at the earliest in the cycle after `done`, i.e. back-to-back runs have a 1-cycle IDLE gap.

## Test plan
- `q_in` held 1 and `start` pulsed, defaults → `done` at cycle 225, `response`=0xFF, `unstable`=0x00, 8 `excite` pulses each 4 cycles wide, spaced 28 cycles apart.
- `q_in` driven per bit to 1,0,1,1,0,0,1,0 (stable within each bit window) → `response`=0x4D, `unstable`=0x00.
- During bit 2's SAMPLE window, `q_in` gives 4 ones of 7 → `response[2]`=1, `unstable[2]`=1. With 3 ones of 7 → `response[2]`=0, `unstable[2]`=1. Other bits unaffected.
- `start` pulsed during EXCITE, SAMPLE and DONE of a run → no restart, `done` still at cycle 225 with a single pulse. `start` in the cycle after `done` → new run begins and `response` clears.
- `rst` asserted for 1 cycle during bit 3 EXCITE → next cycle `excite`=0, `busy`=0, `response`=0, no `done`. A subsequent `start` produces a full, correct run.
- `RESP_BITS`=1, `VOTES`=1, `EXCITE_CYCLES`=1, `SETTLE_CYCLES`=2, `q_in`=1 → `done` in cycle 6, `response`=1, `unstable`=0.
